// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX serializer and the matching receiver.
package uart_pkg;

  localparam int unsigned DEFAULT_CLOCKS_PER_PULSE = 50_000_000 / 19200;
  localparam int unsigned DEFAULT_BITS_PER_WORD    = 8;
  localparam int unsigned DEFAULT_PACKET_SIZE_TX   = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last cycle of each CLOCKS_PER_PULSE period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLOCKS_PER_PULSE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_nxt = '0;
    end
  end

  // tick is registered from the look-ahead count so it lines up with cnt_q == LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tick  <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// Splits a W_OUT-bit bus into BITS_PER_WORD words and sends each as a UART packet.
// Optional even parity bit after the data when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = DEFAULT_BITS_PER_WORD,
  parameter int unsigned PACKET_SIZE_TX   = DEFAULT_PACKET_SIZE_TX,
  parameter int unsigned W_OUT            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_OUT-1:0] s_data,
  output logic             tx
);

  localparam int unsigned N_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned BIT_W   = $clog2(PACKET_SIZE_TX);
  localparam int unsigned WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned IDX_W   = (W_OUT > 1) ? $clog2(W_OUT) : 1;

  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PACKET_SIZE_TX - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(BITS_PER_WORD);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);

  if (W_OUT % BITS_PER_WORD != 0) begin : g_chk_width
    $fatal(1, "W_OUT must be a multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE_TX < BITS_PER_WORD + 2) begin : g_chk_packet
    $fatal(1, "PACKET_SIZE_TX too small for start, data and stop bits");
  end
`ifdef UART_TX_PARITY_EN
  if (PACKET_SIZE_TX < BITS_PER_WORD + 3) begin : g_chk_parity
    $fatal(1, "PACKET_SIZE_TX too small for start, data, parity and stop bits");
  end
`endif
  if (CLOCKS_PER_PULSE < 2) begin : g_chk_pulse
    $fatal(1, "CLOCKS_PER_PULSE must be at least 2");
  end

  tx_state_t         state_q;
  tx_state_t         state_nxt;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_nxt;
  logic [WORD_W-1:0] word_cnt_q;
  logic [WORD_W-1:0] word_cnt_nxt;
  logic [W_OUT-1:0]  shreg_q;
  logic [W_OUT-1:0]  shreg_nxt;
  logic              tx_nxt;
  logic              s_ready_nxt;
  logic              baud_clear;
  logic              tick;
  logic              line_bit;
  logic [IDX_W-1:0]  data_idx;

  uart_baud_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // Line level for the current bit of the current word (word 0 sits in the low bits of shreg_q)
  always_comb begin
    data_idx = IDX_W'(bit_cnt_q - BIT_W'(1));
    line_bit = 1'b1;
    if (bit_cnt_q == '0) begin
      line_bit = 1'b0;
    end else if (bit_cnt_q <= DATA_LAST) begin
      line_bit = shreg_q[data_idx];
`ifdef UART_TX_PARITY_EN
    end else if (bit_cnt_q == DATA_LAST + BIT_W'(1)) begin
      line_bit = even_parity(32'(shreg_q[BITS_PER_WORD-1:0]));
`endif
    end
  end

  always_comb begin
    state_nxt    = state_q;
    bit_cnt_nxt  = bit_cnt_q;
    word_cnt_nxt = word_cnt_q;
    shreg_nxt    = shreg_q;
    tx_nxt       = 1'b1;
    baud_clear   = 1'b1;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          state_nxt    = SEND;
          bit_cnt_nxt  = '0;
          word_cnt_nxt = '0;
          shreg_nxt    = s_data;
        end
      end
      SEND: begin
        baud_clear = 1'b0;
        tx_nxt     = line_bit;
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_nxt = '0;
            shreg_nxt   = shreg_q >> BITS_PER_WORD;
            if (word_cnt_q == LAST_WORD) begin
              state_nxt = IDLE;
            end else begin
              word_cnt_nxt = word_cnt_q + WORD_W'(1);
            end
          end else begin
            bit_cnt_nxt = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    s_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      tx         <= 1'b1;
      s_ready    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      word_cnt_q <= word_cnt_nxt;
      shreg_q    <= shreg_nxt;
      tx         <= tx_nxt;
      s_ready    <= s_ready_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer; honours UART_TX_PARITY_EN when defined.
module tb_uart_tx_serializer;

  localparam int C    = 8;
  localparam int BPW  = 8;
  localparam int P    = 13;
  localparam int W    = 16;
  localparam int N    = W / BPW;
  localparam int BUSY = N * P * C;
  localparam int TP   = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         tx;

  int  errors = 0;
  int  checks = 0;
  logic last_rdy;
  bit  expect_b2b;
  time prev_start;

  uart_tx_serializer #(
    .CLOCKS_PER_PULSE(C),
    .BITS_PER_WORD   (BPW),
    .PACKET_SIZE_TX  (P),
    .W_OUT           (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level of packet-bit idx for a bus, straight from the framing rules
  function automatic logic exp_bit(input logic [W-1:0] d, input int idx);
    int w = idx / P;
    int b = idx % P;
    logic [BPW-1:0] word;
    word = BPW'(d >> (w * BPW));
    if (b == 0) return 1'b0;
    if (b <= BPW) return word[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == BPW + 1) return ^word;
`endif
    return 1'b1;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!last_rdy && n < 50) begin
      @(posedge clk); #1;
      last_rdy = s_ready;
      n++;
    end
    check("ready_timeout", 32'(last_rdy), 32'd1);
  endtask

  task automatic drive_mode(input int mode);
    case (mode)
      1: begin s_valid = 1'b1; s_data = 16'h1234; end
      2: begin s_valid = 1'($urandom); s_data = W'($urandom); end
      default: s_valid = 1'b0;
    endcase
  endtask

  // mode: 0 quiet, 1 hold s_valid with 16'h1234, 2 random inputs during SEND
  task automatic run_bus(input logic [W-1:0] d, input int mode, input bit b2b,
                         input logic [W-1:0] next_d);
    logic [BPW-1:0] got [N];
    int idx;
    s_valid = 1'b1;
    s_data  = d;
    wait_ready();
    @(posedge clk); #1;
    drive_mode(mode);
    for (int m = 1; m <= BUSY; m++) begin
      @(posedge clk); #1;
      idx = (m - 1) / C;
      check($sformatf("tx_%04h_m%0d", d, m), 32'(tx), 32'(exp_bit(d, idx)));
      check($sformatf("rdy_%04h_m%0d", d, m), 32'(s_ready), 32'(m == BUSY));
      if (m == 1) begin
        if (expect_b2b) check("b2b_spacing", 32'($time - prev_start), 32'((BUSY + 1) * TP));
        prev_start = $time;
      end
      if (((m - 1) % C) == C / 2 && (idx % P) >= 1 && (idx % P) <= BPW)
        got[idx / P][(idx % P) - 1] = tx;
      if (m < BUSY - 1) begin
        drive_mode(mode);
      end else begin
        s_valid = b2b;
        if (b2b) s_data = next_d;
      end
    end
    last_rdy   = s_ready;
    expect_b2b = b2b;
    for (int w = 0; w < N; w++)
      check($sformatf("word_%04h_%0d", d, w), 32'(got[w]), 32'(BPW'(d >> (w * BPW))));
  endtask

  initial begin
    logic [W-1:0] d;
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    last_rdy   = 1'b0;
    expect_b2b = 1'b0;
    prev_start = 0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_rdy", 32'(s_ready), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("rdy_before_edge", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("rdy_after_release", 32'(s_ready), 32'd1);
    check("idle_tx", 32'(tx), 32'd1);
    last_rdy = s_ready;

    run_bus(16'hA53C, 0, 1'b0, '0);
    run_bus(16'h0000, 0, 1'b1, 16'hFFFF);
    run_bus(16'hFFFF, 0, 1'b0, '0);
    run_bus(16'hC3A5, 1, 1'b0, '0);
    repeat (3) run_bus(W'($urandom), 2, 1'b0, '0);
    run_bus(W'($urandom), 0, 1'b1, 16'h5AA5);
    run_bus(16'h5AA5, 2, 1'b0, '0);
    run_bus(16'h0107, 0, 1'b0, '0);
    run_bus(16'h0000, 0, 1'b0, '0);

    // Reset during data bit 3 of word 1 (forced to 0 so the jump to 1 is visible)
    d = W'($urandom) & 16'hF7FF;
    s_valid = 1'b1;
    s_data  = d;
    wait_ready();
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int m = 1; m <= P * C + 4 * C + 4; m++) begin
      @(posedge clk); #1;
      check($sformatf("pre_rst_tx_m%0d", m), 32'(tx), 32'(exp_bit(d, (m - 1) / C)));
    end
    #2 rst = 1'b1;
    #1 check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_rdy", 32'(s_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("mid_rst_hold_tx", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_mid_rst", 32'(s_ready), 32'd1);
    check("tx_after_mid_rst", 32'(tx), 32'd1);
    last_rdy   = s_ready;
    expect_b2b = 1'b0;
    run_bus(16'h0081, 0, 1'b0, '0);

    repeat (20) begin
      @(posedge clk); #1;
      check("final_idle_tx", 32'(tx), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
